// File: rtl/if_stage_if.sv
// Bundle of signals between the fetch stage and its surroundings.
// Inputs are stall, redirect, the redirect target and the fetched word; outputs are the fetch address and IF/ID contents.
interface if_stage_if #(
  parameter int XLEN = 32
) ();
  logic            stall;
  logic            redirect;
  logic [XLEN-1:0] redirect_target;
  logic [XLEN-1:0] imem_addr;
  logic [31:0]     imem_rdata;
  logic [XLEN-1:0] if_id_pc;
  logic [31:0]     if_id_instr;
  logic            if_id_valid;
  logic [XLEN-1:0] fetch_count;

  // The fetch stage itself.
  modport master (
    input  stall, redirect, redirect_target, imem_rdata,
    output imem_addr, if_id_pc, if_id_instr, if_id_valid, fetch_count
  );

  // Hazard unit, branch resolution and instruction memory.
  modport slave (
    output stall, redirect, redirect_target, imem_rdata,
    input  imem_addr, if_id_pc, if_id_instr, if_id_valid, fetch_count
  );
endinterface

// File: rtl/if_stage.sv
// Instruction fetch stage: PC register, combinational imem read, IF/ID latch.
// Edge priority is reset, then redirect (flush), then stall (hold), then advance.
module if_stage #(
  parameter int               XLEN         = 32,
  parameter logic [XLEN-1:0]  RESET_VECTOR = 32'h00000000,
  parameter logic [31:0]      NOP_INSTR    = 32'h00000013
) (
  input  logic        clk,
  input  logic        rst,
  if_stage_if.master  bus
);

  logic [XLEN-1:0] pc;
  logic [XLEN-1:0] if_id_pc_q;
  logic [31:0]     if_id_instr_q;
  logic            if_id_valid_q;
  logic [XLEN-1:0] fetch_count_q;
  logic [XLEN-1:0] pc_plus4;
  logic [XLEN-1:0] target_aligned;

  // Both additions wrap naturally at the register width.
  assign pc_plus4       = pc + XLEN'(4);
  assign target_aligned = {bus.redirect_target[XLEN-1:2], 2'b00};

  always_ff @(posedge clk) begin
    if (rst) begin
      pc            <= RESET_VECTOR;
      if_id_pc_q    <= '0;
      if_id_instr_q <= NOP_INSTR;
      if_id_valid_q <= 1'b0;
      fetch_count_q <= '0;
    end else if (bus.redirect) begin
      // The word currently being fetched is on the wrong path, so a bubble goes into IF/ID.
      pc            <= target_aligned;
      if_id_pc_q    <= '0;
      if_id_instr_q <= NOP_INSTR;
      if_id_valid_q <= 1'b0;
    end else if (!bus.stall) begin
      pc            <= pc_plus4;
      if_id_pc_q    <= pc;
      if_id_instr_q <= bus.imem_rdata;
      if_id_valid_q <= 1'b1;
      fetch_count_q <= fetch_count_q + XLEN'(1);
    end
  end

  assign bus.imem_addr   = pc;
  assign bus.if_id_pc    = if_id_pc_q;
  assign bus.if_id_instr = if_id_instr_q;
  assign bus.if_id_valid = if_id_valid_q;
  assign bus.fetch_count = fetch_count_q;

endmodule

// File: tb/tb_if_stage.sv
// Directed bench for if_stage: reset, advance, stall, redirect, flush priority, PC wrap.
// The main instance fetches from a small imem model; a second instance starts near the top of the address space.
module tb_if_stage;

  logic clk;
  logic rst;
  int   n_checks;
  int   n_fail;

  if_stage_if #(.XLEN(32)) bus ();
  if_stage_if #(.XLEN(32)) bus_wrap ();

  if_stage #(
    .XLEN(32), .RESET_VECTOR(32'h00000000), .NOP_INSTR(32'h00000013)
  ) dut (
    .clk(clk), .rst(rst), .bus(bus)
  );

  if_stage #(
    .XLEN(32), .RESET_VECTOR(32'hFFFFFFF8), .NOP_INSTR(32'h00000013)
  ) dut_wrap (
    .clk(clk), .rst(rst), .bus(bus_wrap)
  );

  // Instruction memory: three program words, then a pattern tagged with the address.
  function automatic logic [31:0] imem_word(input logic [31:0] addr);
    case (addr)
      32'h0:   imem_word = 32'h00500093;
      32'h4:   imem_word = 32'h00A00113;
      32'h8:   imem_word = 32'hFFF00193;
      default: imem_word = 32'h10000000 | addr;
    endcase
  endfunction

  assign bus.imem_rdata           = imem_word(bus.imem_addr);
  assign bus_wrap.imem_rdata      = 32'h00000013;
  assign bus_wrap.stall           = 1'b0;
  assign bus_wrap.redirect        = 1'b0;
  assign bus_wrap.redirect_target = 32'h0;

  // clock/reset block
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %08h expected %08h", tag, obs, exp);
    end
  endtask

  // Advance one rising edge and settle just past it.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check_ifid(input string tag, input logic [31:0] pc, input logic [31:0] instr,
                            input logic valid, input logic [31:0] cnt, input logic [31:0] addr);
    check({tag, ".if_id_pc"},    bus.if_id_pc,    pc);
    check({tag, ".if_id_instr"}, bus.if_id_instr, instr);
    check({tag, ".if_id_valid"}, bus.if_id_valid, valid);
    check({tag, ".fetch_count"}, bus.fetch_count, cnt);
    check({tag, ".imem_addr"},   bus.imem_addr,   addr);
  endtask

  initial begin
    n_checks = 0;
    n_fail   = 0;
    rst = 1'b1;
    bus.stall = 1'b0;
    bus.redirect = 1'b0;
    bus.redirect_target = 32'h0;

    step();
    step();
    check_ifid("reset", 32'h0, 32'h00000013, 1'b0, 32'd0, 32'h0);
    check("wrap_reset_addr", bus_wrap.imem_addr, 32'hFFFFFFF8);

    rst = 1'b0;
    step();
    check_ifid("edge1", 32'h0, 32'h00500093, 1'b1, 32'd1, 32'h4);
    check("wrap_edge1_addr", bus_wrap.imem_addr, 32'hFFFFFFFC);
    step();
    check_ifid("edge2", 32'h4, 32'h00A00113, 1'b1, 32'd2, 32'h8);
    check("wrap_edge2_addr", bus_wrap.imem_addr, 32'h00000000);

    // Hold for two edges with PC at 8.
    bus.stall = 1'b1;
    for (int i = 0; i < 2; i++) begin
      step();
      check_ifid("stall", 32'h4, 32'h00A00113, 1'b1, 32'd2, 32'h8);
    end
    bus.stall = 1'b0;
    step();
    check_ifid("post_stall", 32'h8, 32'hFFF00193, 1'b1, 32'd3, 32'hC);

    // Redirect from PC 0x0C to 0x20.
    bus.redirect = 1'b1;
    bus.redirect_target = 32'h20;
    step();
    check_ifid("redirect", 32'h0, 32'h00000013, 1'b0, 32'd3, 32'h20);
    bus.redirect = 1'b0;
    step();
    check_ifid("after_redirect", 32'h20, 32'h10000020, 1'b1, 32'd4, 32'h24);

    // Redirect wins over stall; low target bits are dropped.
    bus.redirect = 1'b1;
    bus.stall = 1'b1;
    bus.redirect_target = 32'h43;
    step();
    check_ifid("redir_stall", 32'h0, 32'h00000013, 1'b0, 32'd4, 32'h40);
    bus.redirect = 1'b0;
    bus.stall = 1'b0;
    step();
    check_ifid("after_redir_stall", 32'h40, 32'h10000040, 1'b1, 32'd5, 32'h44);

    // Reset mid-run overrides stall and redirect.
    rst = 1'b1;
    bus.stall = 1'b1;
    bus.redirect = 1'b1;
    bus.redirect_target = 32'h80;
    step();
    check_ifid("mid_reset", 32'h0, 32'h00000013, 1'b0, 32'd0, 32'h0);
    rst = 1'b0;
    bus.stall = 1'b0;
    bus.redirect = 1'b0;
    step();
    check_ifid("restart", 32'h0, 32'h00500093, 1'b1, 32'd1, 32'h4);

    // Redirect in the very first cycle after reset release.
    rst = 1'b1;
    step();
    rst = 1'b0;
    bus.redirect = 1'b1;
    bus.redirect_target = 32'h9;
    step();
    check_ifid("first_cycle_redir", 32'h0, 32'h00000013, 1'b0, 32'd0, 32'h8);
    bus.redirect = 1'b0;
    step();
    check_ifid("first_cycle_after", 32'h8, 32'hFFF00193, 1'b1, 32'd1, 32'hC);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/if_stage.md
IF_STAGE -- requirements
Module: if_stage

Interface
REQ-001 Parameter XLEN, default 32, datapath and PC width in bits.
REQ-002 Parameter RESET_VECTOR, default 32'h00000000, PC value loaded at reset.
REQ-003 Parameter NOP_INSTR, default 32'h00000013 (addi x0,x0,0), bubble encoding.
REQ-004 clk  input  1  single clock; all state updates on rising edge.
REQ-005 rst  input  1  reset, synchronous, active-high.
REQ-006 stall  input  1  hazard-unit request to hold PC and IF/ID.
REQ-007 redirect  input  1  taken branch/jump resolved downstream.
REQ-008 redirect_target  input  XLEN  byte address of next fetch on redirect.
REQ-009 imem_addr  output  XLEN  byte address to instruction memory, equal to current PC.
REQ-010 imem_rdata  input  32  instruction word, combinational (same-cycle) read of imem_addr.
REQ-011 if_id_pc  output  XLEN  PC of the instruction held in IF/ID.
REQ-012 if_id_instr  output  32  instruction held in IF/ID.
REQ-013 if_id_valid  output  1  IF/ID holds a real instruction, not a bubble.
REQ-014 fetch_count  output  XLEN  number of instructions latched valid into IF/ID since reset.

Function
REQ-015 The block SHALL hold a PC register driven to imem_addr with no added delay.
REQ-016 Per-edge priority SHALL be: rst > redirect > stall > normal advance.
REQ-017 Normal advance: PC <= PC+4; IF/ID <= {pc=PC, instr=imem_rdata, valid=1}; fetch_count +1.
REQ-018 Stall (redirect=0): PC, if_id_pc, if_id_instr, if_id_valid, fetch_count SHALL all hold.
REQ-019 Redirect (stall ignored): PC <= {redirect_target[XLEN-1:2],2'b00}; IF/ID <= {pc=0, instr=NOP_INSTR, valid=0}; fetch_count holds.
REQ-020 Fetch latency SHALL be one cycle: the word at PC appears on if_id_instr after the next rising edge.
REQ-021 PC+4 SHALL wrap modulo 2^XLEN (e.g. FFFFFFFC -> 00000000), with no flag or trap.
REQ-022 fetch_count SHALL wrap modulo 2^XLEN.
REQ-023 redirect_target bits [1:0] SHALL be ignored; no misalignment exception is raised.
REQ-024 A redirect in the first cycle after reset release SHALL take effect normally; no fetch is lost or duplicated beyond the flushed slot.
REQ-025 Outputs SHALL change only on the rising edge of clk, except imem_addr, which tracks the PC register.

Reset
REQ-026 On a rising edge with rst=1: PC <= RESET_VECTOR, if_id_pc <= 0, if_id_instr <= NOP_INSTR, if_id_valid <= 0, fetch_count <= 0.
REQ-027 rst SHALL override stall and redirect in the same cycle.
REQ-028 rst asserted mid-operation SHALL discard the IF/ID contents and restart fetch from RESET_VECTOR on the first edge after release.

Verification
REQ-029 Reset and advance: imem holds 00500093, 00A00113, FFF00193 at 0/4/8; rst high 2 cycles, then low -> edge 1: if_id_pc=0, instr=00500093, valid=1; edge 3: if_id_pc=8, instr=FFF00193, fetch_count=3.
REQ-030 Stall: stall=1 for 2 cycles while PC=8 -> imem_addr stays 8, IF/ID and fetch_count unchanged; after release, next edge latches pc=8.
REQ-031 Redirect: redirect=1, target=0x20 at PC=0x0C -> next edge PC=0x20, if_id_valid=0, instr=00000013; following edge if_id_pc=0x20, valid=1.
REQ-032 Redirect+stall together, target=0x43 -> PC=0x40, IF/ID flushed, fetch_count unchanged.
REQ-033 Wrap: RESET_VECTOR=FFFFFFF8 -> imem_addr sequence FFFFFFF8, FFFFFFFC, 00000000.
REQ-034 Reset mid-run with stall=1 and redirect=1 asserted -> PC=RESET_VECTOR, valid=0, fetch_count=0 after the reset edge.
